au_be_gen: RTL

AU_BE_GEN -- requirements
Module: au_be_gen

---
 rtl/au_be_gen_pkg.sv | 26 ++
 rtl/au_be_gen_mask.sv | 14 +
 rtl/au_be_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/au_be_gen_pkg.sv
// Shared types, constants and byte-enable mask helpers for the au_be_gen block.
// The DROP state exists only when AU_BE_GEN_ERR_EN is defined.
package au_be_gen_pkg;

    localparam int WORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
`ifdef AU_BE_GEN_ERR_EN
        ,
        DROP = 2'd2
`endif
    } state_e;

    // Lanes at and above the destination offset carry frame bytes.
    function automatic logic [7:0] be_first(input logic [2:0] addr);
        return 8'hFF << addr;
    endfunction

    // Lanes at and below the lane holding the final frame byte carry frame bytes.
    function automatic logic [7:0] be_last(input logic [2:0] last_lane);
        return 8'hFF >> (3'd7 - last_lane);
    endfunction

endpackage

// File: rtl/au_be_gen_mask.sv
// Combinational first/last-word byte-enable mask generator for au_be_gen.
module au_be_mask
    import au_be_gen_pkg::*;
(
    input  logic [2:0] addr_i,
    input  logic [2:0] last_lane_i,
    output logic [7:0] first_be_o,
    output logic [7:0] last_be_o
);

    assign first_be_o = be_first(addr_i);
    assign last_be_o  = be_last(last_lane_i);

endmodule

// File: rtl/au_be_gen.sv
// Byte-enable generator: tags aligned 64-bit frame words with SOF/EOF and lane enables.
// Define AU_BE_GEN_ERR_EN to compile in length/framing checks (ERR_LEN, DROP state).
module au_be_gen
    import au_be_gen_pkg::*;
#(
    parameter int LEN_WIDTH = 12
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [2:0]           CMD_DST_ADDR,
    input  logic [LEN_WIDTH-1:0] CMD_LEN,
    input  logic                 CMD_VLD,
    output logic                 CMD_RDY,
    input  logic [63:0]          IN_DATA,
    input  logic                 IN_SOF,
    input  logic                 IN_EOF,
    input  logic                 IN_SRC_RDY,
    output logic                 IN_DST_RDY,
    output logic [63:0]          OUT_DATA,
    output logic [7:0]           OUT_BE,
    output logic                 OUT_SOF,
    output logic                 OUT_EOF,
    output logic                 OUT_SRC_RDY,
    input  logic                 OUT_DST_RDY,
    output logic                 ERR_LEN
);

    localparam logic [LEN_WIDTH:0] CNT_ONE = (LEN_WIDTH+1)'(1);

    state_e               state_q, state_d;
    logic [LEN_WIDTH:0]   cnt_q, cnt_d;
    logic [2:0]           addr_q, addr_d;
    logic [2:0]           lane_q, lane_d;
    logic                 first_q, first_d;
    logic                 out_vld_q, out_vld_d;
    logic [63:0]          out_data_q, out_data_d;
    logic [7:0]           out_be_q, out_be_d;
    logic                 out_sof_q, out_sof_d;
    logic                 out_eof_q, out_eof_d;
    logic                 err_q, err_d;

    logic [LEN_WIDTH:0]   cmd_sum;
    logic [LEN_WIDTH:0]   cmd_words;
    logic [2:0]           cmd_last_lane;
    logic                 cmd_len_zero;
    logic [7:0]           first_be;
    logic [7:0]           last_be;
    logic                 in_xfer;
    logic                 last_word;
    logic                 unused_in;

    // Frame sideband that does not steer this block (SOF always; EOF without checking).
    assign unused_in = IN_SOF ^ IN_EOF;

    // Words spanned = ceil((offset + length) / 8), widened one bit to avoid overflow.
    assign cmd_sum       = {1'b0, CMD_LEN} + {{(LEN_WIDTH-2){1'b0}}, CMD_DST_ADDR}
                         + (LEN_WIDTH+1)'(WORD_BYTES - 1);
    assign cmd_words     = cmd_sum >> 3;
    assign cmd_last_lane = CMD_DST_ADDR + CMD_LEN[2:0] - 3'd1;
    assign cmd_len_zero  = (CMD_LEN == '0);

    au_be_mask u_mask (
        .addr_i      (addr_q),
        .last_lane_i (lane_q),
        .first_be_o  (first_be),
        .last_be_o   (last_be)
    );

    assign last_word = (cnt_q == CNT_ONE);
    assign in_xfer   = IN_SRC_RDY && IN_DST_RDY;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            lane_q     <= '0;
            first_q    <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_be_q   <= '0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            first_q    <= first_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_be_q   <= out_be_d;
            out_sof_q  <= out_sof_d;
            out_eof_q  <= out_eof_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        first_d    = first_q;
        out_vld_d  = out_vld_q && !OUT_DST_RDY;
        out_data_d = out_data_q;
        out_be_d   = out_be_q;
        out_sof_d  = out_sof_q;
        out_eof_d  = out_eof_q;
        err_d      = 1'b0;
        CMD_RDY    = 1'b0;
        IN_DST_RDY = 1'b0;

        case (state_q)
            IDLE: begin
                CMD_RDY = 1'b1;
                if (CMD_VLD) begin
                    if (cmd_len_zero) begin
`ifdef AU_BE_GEN_ERR_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        state_d = RUN;
                        cnt_d   = cmd_words;
                        addr_d  = CMD_DST_ADDR;
                        lane_d  = cmd_last_lane;
                        first_d = 1'b1;
                    end
                end
            end

            RUN: begin
                // Accept a word only if the output register is empty or draining now.
                IN_DST_RDY = !out_vld_q || OUT_DST_RDY;
                if (in_xfer) begin
                    out_vld_d  = 1'b1;
                    out_data_d = IN_DATA;
                    out_sof_d  = first_q;
                    out_be_d   = (first_q ? first_be : 8'hFF) & (last_word ? last_be : 8'hFF);
                    out_eof_d  = last_word;
                    first_d    = 1'b0;
                    cnt_d      = cnt_q - CNT_ONE;
                    if (last_word) begin
                        state_d = IDLE;
                    end
`ifdef AU_BE_GEN_ERR_EN
                    if (IN_EOF && !last_word) begin
                        out_be_d  = 8'hFF;
                        out_eof_d = 1'b1;
                        err_d     = 1'b1;
                        state_d   = IDLE;
                    end else if (last_word && !IN_EOF) begin
                        err_d   = 1'b1;
                        state_d = DROP;
                    end
`endif
                end
            end

`ifdef AU_BE_GEN_ERR_EN
            DROP: begin
                IN_DST_RDY = 1'b1;
                if (in_xfer && IN_EOF) begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign OUT_DATA    = out_data_q;
    assign OUT_BE      = out_be_q;
    assign OUT_SOF     = out_sof_q;
    assign OUT_EOF     = out_eof_q;
    assign OUT_SRC_RDY = out_vld_q;
    assign ERR_LEN     = err_q;

endmodule
